des_ip_loader: RTL
==================

# des_ip_loader

Input front end of the DES datapath, the counterpart of the final inverse-permutation stage at the output. Accepts a plaintext/ciphertext stream one byte per handshake, assembles each 8-byte group into a 64-bit block, applies the DES initial permutation (IP) and presents the result as L0/R0 halves to the round engine through a registered valid/ready interface. One assembly buffer and one output register allow the next block to fill while the current one is held.

## Interface
- No parameters.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  `in_byte` valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `in_byte`  in  [1:8]  data byte; bit 1 is the MSB.
- `abort`  in  1  synchronous discard of the partially assembled block.
- `out_valid`  out  1  `l0`/`r0` hold a permuted block.
- `out_ready`  in  1  round engine takes the block this cycle.
- `l0`  out  [1:32]  IP output bits 1..32.
- `r0`  out  [1:32]  IP output bits 33..64.
- `blk_cnt`  out  [15:0]  blocks delivered; present only with `DES_IP_BLKCNT_EN`.

## Operation
- Byte transfer occurs when `in_valid && in_ready`.
- Byte k of a group (k = 0..7) fills assembly bits 8k+1..8k+8.
- A 3-bit byte counter tracks the group position and wraps 7 -> 0 on the eighth byte.
- On the eighth byte, the output register loads IP(assembled block with the incoming byte).
- IP mapping: output bit 8r+c+1 (r, c = 0..7) = input bit (r<4 ? 58+2r : 49+2r) − 8c.
  - Example: out[1] = in[58], out[8] = in[2], out[33] = in[57], out[64] = in[7].
  - The mapping is the exact inverse of the final permutation: IP⁻¹(IP(x)) = x.
- Output state machine, two states:
  - EMPTY (`out_valid` = 0): the eighth byte moves the block to FULL.
  - FULL (`out_valid` = 1): `out_ready` without a simultaneous eighth byte moves to EMPTY.
  - FULL with `out_ready` and a simultaneous eighth byte: the new block replaces the old one and the state stays FULL.
- `in_ready = !(cnt == 7 && out_valid && !out_ready)`.
  - This path is combinational from `out_ready`.
  - Bytes 0..6 are always accepted, even while FULL.
- `l0`/`r0` hold stable while `out_valid && !out_ready`.
- `abort`:
  - Resets the counter to 0 and discards any byte presented in the same cycle.
  - Does not touch the output register or `out_valid`.
  - Takes priority over a simultaneous eighth byte, which is not loaded.
- Reset clears the counter, assembly buffer, `l0`, `r0`, `out_valid` (and `blk_cnt`) to 0. Reset mid-group drops the partial block.

## Timing
- Latency: eighth byte accepted at edge N -> `out_valid` = 1 with data after edge N.
- Throughput: one byte per cycle sustained; a block is offered every 8 cycles with no bubbles when `out_ready` = 1.
- All outputs are registered except `in_ready`.

## Configuration
- `DES_IP_BLKCNT_EN` defined:
  - Adds port `blk_cnt`, a 16-bit counter that increments on each `out_valid && out_ready`.
  - Wraps 0xFFFF -> 0 and resets to 0.
- Not defined: the port and the counter are absent. The rest of the behaviour is identical.

## Test plan
- Known-answer: bytes 01 23 45 67 89 AB CD EF, `out_ready` = 1 -> one cycle later `out_valid` = 1, `l0` = 0xCC00CCFF, `r0` = 0xF0AAF0AA.
- Back-pressure: two blocks back-to-back, `out_ready` = 0 -> `in_ready` drops only at the second block's eighth byte and `l0`/`r0` stay at block 1. Raising `out_ready` takes the byte in the same cycle; block 2 appears on the next cycle with no data loss.
- Simultaneous consume and load: `out_ready` = 1 in the same cycle as the eighth byte while FULL -> `out_valid` stays 1 and the data switches to the new block.
- Abort: abort after 5 bytes, then feed 0123456789ABCDEF -> output is CC00CCFF/F0AAF0AA and the earlier output is unchanged.
- Reset mid-group: assert `rst` after 3 bytes -> all outputs 0 immediately. The next 8 bytes form a complete block.
- Round trip: 1000 random blocks through this stage and a reference IP⁻¹ -> equal to the input. With `DES_IP_BLKCNT_EN`, `blk_cnt` = 1000.

Source files
------------

// File: rtl/des_ip_if.sv
// des_ip_if: byte-stream input and L0/R0 block output of the DES IP loader.
// The "master" modport is the side that sources bytes and sinks blocks;
// the "slave" modport is the loader itself.
interface des_ip_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:8]  in_byte;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [1:32] l0;
    logic [1:32] r0;

    modport master (
        output in_valid, in_byte, abort, out_ready,
        input  in_ready, out_valid, l0, r0
    );

    modport slave (
        input  in_valid, in_byte, abort, out_ready,
        output in_ready, out_valid, l0, r0
    );
endinterface

// File: rtl/des_ip_loader.sv
// des_ip_loader: assembles eight bytes into a 64-bit block, applies the DES
// initial permutation and holds the L0/R0 halves in an output register
// until the round engine takes them.
// Optional feature macro: DES_IP_BLKCNT_EN adds the blk_cnt delivered-block
// counter port.
module des_ip_loader (
    input  logic       clk,
    input  logic       rst,
    des_ip_if.slave    bus
`ifdef DES_IP_BLKCNT_EN
    ,
    output logic [15:0] blk_cnt
`endif
);

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    // DES initial permutation: output bit 8r+c+1 takes input bit base(r)-8c.
    function automatic logic [1:64] ip_perm(input logic [1:64] x);
        logic [1:64] y;
        int          src;
        y = 64'd0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                src = ((r < 4) ? (58 + 2 * r) : (49 + 2 * r)) - 8 * c;
                y[8 * r + c + 1] = x[src];
            end
        end
        return y;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:64] asm_q, asm_d;
    logic [1:32] l0_q, l0_d;
    logic [1:32] r0_q, r0_d;

    logic        in_ready_s;
    logic        accept_s;
    logic        load_s;
    logic [6:0]  slot_s;
    logic [1:64] blk_s;
    logic [1:64] perm_s;

    // The last byte of a group stalls only while a held block is not being taken.
    assign in_ready_s    = !((cnt_q == 3'd7) && (state_q == ST_FULL) && !bus.out_ready);
    assign accept_s      = bus.in_valid && in_ready_s;
    assign load_s        = accept_s && !bus.abort && (cnt_q == 3'd7);
    assign slot_s        = {1'b0, cnt_q, 3'b000} + 7'd1;
    assign blk_s         = {asm_q[1:56], bus.in_byte};
    assign perm_s        = ip_perm(blk_s);

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.l0        = l0_q;
    assign bus.r0        = r0_q;

    // Byte counter and assembly buffer update; abort discards the group and the byte.
    always_comb begin
        cnt_d = cnt_q;
        asm_d = asm_q;
        if (bus.abort) begin
            cnt_d = 3'd0;
        end else if (accept_s) begin
            cnt_d = cnt_q + 3'd1;
            asm_d[slot_s +: 8] = bus.in_byte;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output FSM and output register: a new block may replace one being consumed.
    always_comb begin
        state_d = state_q;
        l0_d    = l0_q;
        r0_d    = r0_q;
        if (load_s) begin
            l0_d = perm_s[1:32];
            r0_d = perm_s[33:64];
        end else begin
            l0_d = l0_q;
            r0_d = r0_q;
        end
        case (state_q)
            ST_EMPTY: begin
                if (load_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (load_s) begin
                    state_d = ST_FULL;
                end else if (bus.out_ready) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State, counter, assembly buffer and output halves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            cnt_q   <= 3'd0;
            asm_q   <= 64'd0;
            l0_q    <= 32'd0;
            r0_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            l0_q    <= l0_d;
            r0_q    <= r0_d;
        end
    end

`ifdef DES_IP_BLKCNT_EN
    logic [15:0] blk_cnt_q;

    // Count blocks handed to the round engine; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_q <= 16'd0;
        end else if ((state_q == ST_FULL) && bus.out_ready) begin
            blk_cnt_q <= blk_cnt_q + 16'd1;
        end else begin
            blk_cnt_q <= blk_cnt_q;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule
